// File: rtl/cash_payment_accumulator.sv
// Cash-path accumulator ahead of the ATP controller. It collects validated notes
// against a latched bill and reports either payment (with change) or a refund.
module cash_payment_accumulator #(
    parameter int AMT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [AMT_W-1:0] i_bill_amount,
    input  logic             i_cancel,
    input  logic             i_note_valid,
    input  logic [2:0]       i_note_denom,
    output logic             o_note_ready,
    output logic             o_note_reject,
    output logic [AMT_W-1:0] o_amount_paid,
    output logic             o_payment_received,
    output logic [AMT_W-1:0] o_change_due,
    output logic             o_refund_valid,
    output logic [AMT_W-1:0] o_refund_amount,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2,
        S_REFUND  = 2'd3
    } state_t;

    state_t            r_state;
    logic [AMT_W-1:0]  r_bill;
    logic [TO_W-1:0]   r_to_cnt;

    logic [AMT_W:0]    w_note_val;
    logic              w_note_ok;
    logic [AMT_W:0]    w_sum;
    logic [AMT_W:0]    w_change;
    logic              w_take;
    logic              w_count;
    logic              w_done;
    logic              w_timeout;
    logic [AMT_W-1:0]  w_paid_next;

    always_comb begin
        w_note_val = '0;
        w_note_ok  = 1'b1;
        case (i_note_denom)
            3'd0:    w_note_val = (AMT_W+1)'(10);
            3'd1:    w_note_val = (AMT_W+1)'(20);
            3'd2:    w_note_val = (AMT_W+1)'(50);
            3'd3:    w_note_val = (AMT_W+1)'(100);
            3'd4:    w_note_val = (AMT_W+1)'(200);
            3'd5:    w_note_val = (AMT_W+1)'(500);
            default: w_note_ok  = 1'b0;
        endcase
    end

    // Sum carries one extra bit so an overflowing note is detected, not wrapped.
    assign w_sum       = {1'b0, o_amount_paid} + w_note_val;
    assign w_change    = w_sum - {1'b0, r_bill};
    assign w_take      = i_note_valid && (r_state == S_COLLECT);
    assign w_count     = w_take && w_note_ok && !w_sum[AMT_W];
    assign w_done      = w_count && (w_sum >= {1'b0, r_bill});
    assign w_timeout   = !w_take && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_paid_next = w_count ? w_sum[AMT_W-1:0] : o_amount_paid;

    assign o_note_ready = (r_state == S_COLLECT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_bill             <= '0;
            r_to_cnt           <= '0;
            o_note_reject      <= 1'b0;
            o_amount_paid      <= '0;
            o_payment_received <= 1'b0;
            o_change_due       <= '0;
            o_refund_valid     <= 1'b0;
            o_refund_amount    <= '0;
            o_busy             <= 1'b0;
        end else begin
            o_note_reject      <= 1'b0;
            o_payment_received <= 1'b0;
            o_refund_valid     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_bill          <= i_bill_amount;
                        r_to_cnt        <= '0;
                        o_amount_paid   <= '0;
                        o_change_due    <= '0;
                        o_refund_amount <= '0;
                        o_busy          <= 1'b1;
                        if (i_bill_amount == '0) begin
                            r_state            <= S_DONE;
                            o_payment_received <= 1'b1;
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    o_amount_paid <= w_paid_next;
                    o_note_reject <= w_take && !w_count;
                    r_to_cnt      <= w_take ? '0 : r_to_cnt + 1'b1;
                    // Completion outranks cancel; cancel outranks timeout.
                    if (w_done) begin
                        r_state            <= S_DONE;
                        o_change_due       <= w_change[AMT_W-1:0];
                        o_payment_received <= 1'b1;
                    end else if (i_cancel || w_timeout) begin
                        r_state         <= S_REFUND;
                        o_refund_amount <= w_paid_next;
                        o_refund_valid  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
                S_REFUND: begin
                    r_state       <= S_IDLE;
                    o_busy        <= 1'b0;
                    o_amount_paid <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cash_payment_accumulator.sv
// Directed bench for cash_payment_accumulator, built narrow (AMT_W=10) with a
// short timeout so overflow and auto-refund are reachable in a few cycles.
module tb_cash_payment_accumulator;

    localparam int AMT_W = 10;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AMT_W-1:0] bill;
    logic             cancel;
    logic             nvalid;
    logic [2:0]       ndenom;
    logic             nready;
    logic             nreject;
    logic [AMT_W-1:0] paid;
    logic             prcv;
    logic [AMT_W-1:0] change;
    logic             rvalid;
    logic [AMT_W-1:0] ramt;
    logic             busy;

    int n_chk  = 0;
    int n_pass = 0;

    cash_payment_accumulator #(
        .AMT_W(AMT_W), .TIMEOUT_CYCLES(TO), .TO_W(5)
    ) dut (
        .clk(clk), .reset(reset), .i_start(start), .i_bill_amount(bill),
        .i_cancel(cancel), .i_note_valid(nvalid), .i_note_denom(ndenom),
        .o_note_ready(nready), .o_note_reject(nreject), .o_amount_paid(paid),
        .o_payment_received(prcv), .o_change_due(change),
        .o_refund_valid(rvalid), .o_refund_amount(ramt), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    // Advance one rising edge; inputs and checks happen 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [AMT_W-1:0] b);
        start = 1'b1; bill = b;
        tick();
        start = 1'b0;
    endtask

    task automatic note(input logic [2:0] d);
        nvalid = 1'b1; ndenom = d;
        tick();
        nvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; bill = '0; cancel = 1'b0;
        nvalid = 1'b0; ndenom = '0;
        tick(); tick();
        chk("rst_paid", paid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", nready, 0);
        chk("rst_prcv", prcv, 0);
        chk("rst_rvalid", rvalid, 0);
        reset = 1'b0;
        tick();

        // Exact pay 350 = 200 + 100 + 50
        arm(350);
        chk("ex_busy", busy, 1);
        chk("ex_ready", nready, 1);
        note(3'd4); chk("ex_p200", paid, 200);
        note(3'd3); chk("ex_p300", paid, 300);
        note(3'd2); chk("ex_p350", paid, 350);
        chk("ex_prcv", prcv, 1);
        chk("ex_change", change, 0);
        chk("ex_ready_done", nready, 0);
        tick();
        chk("ex_prcv_off", prcv, 0);
        chk("ex_busy_off", busy, 0);

        // Overpay 120 with 100 + 50; a third note offered in DONE is not taken
        arm(120);
        note(3'd3); chk("ov_p100", paid, 100);
        note(3'd2);
        chk("ov_prcv", prcv, 1);
        chk("ov_change", change, 30);
        nvalid = 1'b1; ndenom = 3'd3;
        chk("ov_ready_done", nready, 0);
        tick();
        chk("ov_paid_held", paid, 150);
        chk("ov_prcv_once", prcv, 0);
        tick();
        chk("ov_idle_ignored", paid, 150);
        chk("ov_rvalid", rvalid, 0);
        nvalid = 1'b0;

        // Invalid code 7, then cancel with nothing paid
        arm(500);
        note(3'd7);
        chk("inv_reject", nreject, 1);
        chk("inv_paid", paid, 0);
        tick();
        chk("inv_reject_off", nreject, 0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("inv_refund", rvalid, 1);
        chk("inv_ramt", ramt, 0);
        tick();

        // Overflow: paid 990 of 1000, a 500 note would exceed 1023
        arm(1000);
        note(3'd5); note(3'd4); note(3'd4); note(3'd2); note(3'd1); note(3'd1);
        chk("of_p990", paid, 990);
        note(3'd5);
        chk("of_reject", nreject, 1);
        chk("of_paid", paid, 990);
        chk("of_busy", busy, 1);
        note(3'd0);
        chk("of_prcv", prcv, 1);
        chk("of_change", change, 0);
        tick();

        // Cancel after 500 + 200
        arm(1000);
        note(3'd5); note(3'd4);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("cn_rvalid", rvalid, 1);
        chk("cn_ramt", ramt, 700);
        chk("cn_prcv", prcv, 0);
        tick();
        chk("cn_rvalid_off", rvalid, 0);
        chk("cn_paid_clr", paid, 0);
        chk("cn_ramt_held", ramt, 700);
        chk("cn_busy", busy, 0);

        // Cancel with a completing note: completion wins
        arm(1000);
        note(3'd5);
        cancel = 1'b1; note(3'd5); cancel = 1'b0;
        chk("cw_prcv", prcv, 1);
        chk("cw_change", change, 0);
        chk("cw_rvalid", rvalid, 0);
        tick();
        chk("cw_rvalid2", rvalid, 0);

        // Cancel with a counted non-completing note: refund includes it
        arm(1000);
        note(3'd5);
        cancel = 1'b1; note(3'd4); cancel = 1'b0;
        chk("cc_rvalid", rvalid, 1);
        chk("cc_ramt", ramt, 700);
        tick();

        // Timeout 16 cycles after the last handshake edge
        arm(100);
        note(3'd2);
        for (int i = 0; i < TO - 1; i++) tick();
        chk("to_early", rvalid, 0);
        tick();
        chk("to_rvalid", rvalid, 1);
        chk("to_ramt", ramt, 50);
        tick();

        // Note at cycle 10 restarts the count
        arm(100);
        note(3'd2);
        for (int i = 0; i < 9; i++) tick();
        note(3'd1);
        chk("tr_paid", paid, 70);
        for (int i = 0; i < TO - 1; i++) tick();
        chk("tr_early", rvalid, 0);
        chk("tr_busy", busy, 1);
        tick();
        chk("tr_rvalid", rvalid, 1);
        chk("tr_ramt", ramt, 70);
        tick();

        // Zero bill completes immediately
        arm(0);
        chk("zb_prcv", prcv, 1);
        chk("zb_change", change, 0);
        tick();
        chk("zb_prcv_off", prcv, 0);
        chk("zb_busy", busy, 0);

        // Async reset mid-COLLECT with 300 paid
        arm(1000);
        note(3'd4); note(3'd3);
        chk("rs_p300", paid, 300);
        reset = 1'b1;
        #1;
        chk("rs_paid", paid, 0);
        chk("rs_busy", busy, 0);
        chk("rs_ready", nready, 0);
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("rs_prcv", prcv, 0);
        chk("rs_rvalid", rvalid, 0);
        chk("rs_ramt", ramt, 0);
        arm(100);
        chk("rs_rearm", busy, 1);
        note(3'd3);
        chk("rs_done", prcv, 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cash_payment_accumulator.md
Name: cash_payment_accumulator

Overview:
Cash-path stage that sits directly upstream of the ATP machine controller and produces its paymentReceived input. It is armed while the controller is in its accept-cash state. It accepts validated notes from the note-reader front end through a valid/ready handshake and accumulates the paid amount against the latched bill amount. It then emits a one-cycle payment_received pulse with the change due, or a refund on cancel or timeout.

Parameters:
AMT_W, 16, width of bill/paid/change/refund amounts in rupees (unsigned)
TIMEOUT_CYCLES, 1000000, idle cycles in COLLECT with no accepted note before auto-refund (>=2)
TO_W, 20, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  arm pulse (driven from acceptCash rising edge); sampled only in IDLE
bill_amount  in  AMT_W  bill value; latched on accepted start
cancel  in  1  user cancel request
note_valid  in  1  note reader presents a note
note_denom  in  3  denomination code: 0=10, 1=20, 2=50, 3=100, 4=200, 5=500, 6/7 invalid
note_ready  out  1  block can take a note this cycle
note_reject  out  1  one-cycle pulse: last handshaken note was not counted (return it)
amount_paid  out  AMT_W  running accumulated total
payment_received  out  1  one-cycle pulse: bill fully paid (to controller paymentReceived)
change_due  out  AMT_W  amount_paid minus bill, valid from payment_received until next start
refund_valid  out  1  one-cycle pulse: transaction aborted
refund_amount  out  AMT_W  amount to return, valid with refund_valid, held until next start
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0; bill register and timeout counter 0.
- All outputs except note_ready are registered. note_ready = (state==COLLECT), combinational from the state register.
- States: IDLE, COLLECT, DONE, REFUND.
- IDLE:
  - start=1 and bill_amount>0 -> latch bill, clear amount_paid/change_due/refund_amount/timeout counter, go to COLLECT.
  - start=1 and bill_amount==0 -> clear the same registers, go to DONE with change_due=0.
  - cancel and note_valid are ignored in IDLE.
- COLLECT:
  - Handshake: a note is taken in any cycle with note_valid && note_ready. The front end holds note_valid/note_denom until taken.
  - Valid code: sum = amount_paid + value(note_denom), computed at AMT_W+1 bits.
    - sum > 2^AMT_W-1 -> note not counted; note_reject=1 for the following cycle.
    - Otherwise amount_paid<=sum at that edge.
  - Code 6/7 -> not counted, note_reject pulse next cycle, amount_paid unchanged.
  - Any handshaken note, counted or rejected, resets the timeout counter to 0. Otherwise the counter increments each cycle.
  - Transition priority, evaluated on the same edge:
    1. sum >= bill (note counted) -> go to DONE; change_due<=sum-bill.
    2. cancel=1 -> go to REFUND; refund_amount<=amount_paid including any note counted this cycle.
    3. counter==TIMEOUT_CYCLES-1 with no handshake -> go to REFUND, same refund rule.
  - Completion beats a simultaneous cancel. start in COLLECT is ignored.
- DONE: payment_received=1 for exactly this one cycle; then go to IDLE. change_due and amount_paid are held.
- REFUND: refund_valid=1 for exactly this one cycle; then go to IDLE. refund_amount is held. amount_paid is cleared on entry to IDLE.
- Latency:
  - Note handshake at edge N -> amount_paid updated at N.
  - If that note completes payment, payment_received is high during cycle N..N+1.
  - Reject pulse is high during cycle N..N+1.
- payment_received and refund_valid are never high in the same cycle. There is at most one of them per start.
- Reset mid-COLLECT: everything is cleared immediately. No payment_received or refund pulse is emitted, and accumulated cash is not reported.

Test Plan:
- Exact pay: start with bill=350; notes 200, 100, 50 -> amount_paid 200, 300, 350. payment_received pulses one cycle after the 50 handshake; change_due=0; busy drops the next cycle.
- Overpay: bill=120; notes 100, 50 -> payment_received once, change_due=30. note_ready is low in DONE, so a third offered note is not taken.
- Invalid/overflow: bill=500; note_denom=7 -> note_reject pulse, amount_paid stays 0. With AMT_W=10 and a bill of 1000, paid 1000-10 via notes, then note 500 -> note_reject and amount_paid unchanged.
- Cancel: bill=1000; notes 500, 200, then cancel -> refund_valid pulse with refund_amount=700 and no payment_received. Cancel in the same cycle as a 500 note with bill 1000 and paid 500 -> payment_received, change_due=0, no refund.
- Timeout: with TIMEOUT_CYCLES=16, bill=100, note 50, then idle -> refund_valid exactly 16 cycles after the handshake edge with refund_amount=50. A note at cycle 10 restarts the count.
- Zero bill and reset: start with bill=0 -> payment_received the next cycle, change_due=0. Async reset asserted mid-COLLECT with paid=300 -> all outputs 0 immediately, no pulses after release, and start is accepted again.
